// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: opcodes, widths and shared types for the integer ALU reservation station.
package alu_rs_pkg;

   localparam int DATA_W      = 32;
   localparam int OPCODE_W    = 6;
   localparam int ROBENTRY    = 4;
   localparam int RS_SIZE_DEF = 16;

   localparam logic [OPCODE_W-1:0] OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,
                                   OP_SLT   = 6'd3,  OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,
                                   OP_SRL   = 6'd6,  OP_SRA   = 6'd7,  OP_OR    = 6'd8,
                                   OP_AND   = 6'd9,  OP_ADDI  = 6'd10, OP_SLTI  = 6'd11,
                                   OP_SLTIU = 6'd12, OP_XORI  = 6'd13, OP_ORI   = 6'd14,
                                   OP_ANDI  = 6'd15, OP_SLLI  = 6'd16, OP_SRLI  = 6'd17,
                                   OP_SRAI  = 6'd18, OP_LUI   = 6'd19, OP_AUIPC = 6'd20,
                                   OP_BEQ   = 6'd21, OP_BNE   = 6'd22, OP_BLT   = 6'd23,
                                   OP_BGE   = 6'd24, OP_BLTU  = 6'd25, OP_BGEU  = 6'd26,
                                   OP_JAL   = 6'd27, OP_JALR  = 6'd28;

   // Width of an entry index for a station of n entries.
   function automatic int rs_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] val;
   } snoop_t;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB snoop and ALU-issue signals of the ALU reservation station.
// Build option RS_LSB_SNOOP_EN adds the load/store CDB signals.
interface alu_rs_if #(
   parameter int ROB_W = alu_rs_pkg::ROBENTRY
) ();

   logic             issue_sgn;
   logic [5:0]       issue_opcode;
   logic [31:0]      issue_vj, issue_vk, issue_imm, issue_pc;
   logic [ROB_W-1:0] issue_qj, issue_qk, issue_rob;
   logic             issue_qj_rdy, issue_qk_rdy;
   logic             rs_full;

   logic             cdb_sgn;
   logic [ROB_W-1:0] cdb_rob;
   logic [31:0]      cdb_val;
`ifdef RS_LSB_SNOOP_EN
   logic             lsb_cdb_sgn;
   logic [ROB_W-1:0] lsb_cdb_rob;
   logic [31:0]      lsb_cdb_val;
`endif

   logic             RS_sgn;
   logic [5:0]       RS_opcode;
   logic [31:0]      lhs, rhs, imm, pc;
   logic [ROB_W-1:0] ROB_entry;

   modport master (
`ifdef RS_LSB_SNOOP_EN
      output lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val,
`endif
      output issue_sgn, issue_opcode, issue_vj, issue_vk, issue_imm, issue_pc,
      output issue_qj, issue_qk, issue_rob, issue_qj_rdy, issue_qk_rdy,
      output cdb_sgn, cdb_rob, cdb_val,
      input  rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
   );

   modport slave (
`ifdef RS_LSB_SNOOP_EN
      input  lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val,
`endif
      input  issue_sgn, issue_opcode, issue_vj, issue_vk, issue_imm, issue_pc,
      input  issue_qj, issue_qk, issue_rob, issue_qj_rdy, issue_qk_rdy,
      input  cdb_sgn, cdb_rob, cdb_val,
      output rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
   );

endinterface

// File: rtl/alu_rs_select.sv
// alu_rs_select: combinational lowest-index priority encoder over an N-bit request vector.
module alu_rs_select
   import alu_rs_pkg::*;
#(
   parameter int N = RS_SIZE_DEF
) (
   input  logic [N-1:0]             req,
   output logic [rs_idx_w(N)-1:0]   idx,
   output logic                     any
);

   localparam int IW = rs_idx_w(N);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station; holds dispatched ops until both operands are ready, issues one per cycle.
// Build option: define RS_LSB_SNOOP_EN to also snoop the load/store CDB for wakeup and dispatch bypass.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF,
   parameter int ROB_W   = ROBENTRY
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    rdy,
   input  logic    flush,
   alu_rs_if.slave bus
);

   localparam int IW = rs_idx_w(RS_SIZE);

   logic [RS_SIZE-1:0]  busy, rj, rk, wake_j, wake_k, ready_req;
   logic [OPCODE_W-1:0] op_q  [RS_SIZE];
   logic [DATA_W-1:0]   vj_q  [RS_SIZE];
   logic [DATA_W-1:0]   vk_q  [RS_SIZE];
   logic [DATA_W-1:0]   imm_q [RS_SIZE];
   logic [DATA_W-1:0]   pc_q  [RS_SIZE];
   logic [ROB_W-1:0]    qj_q  [RS_SIZE];
   logic [ROB_W-1:0]    qk_q  [RS_SIZE];
   logic [ROB_W-1:0]    rob_q [RS_SIZE];
   snoop_t              sj    [RS_SIZE];
   snoop_t              sk    [RS_SIZE];
   snoop_t              in_j, in_k;

   logic                lsb_sgn;
   logic [ROB_W-1:0]    lsb_rob;
   logic [DATA_W-1:0]   lsb_val;

   logic [IW-1:0]       free_idx, sel_idx;
   logic                free_any, sel_any;
   logic                run_p0, alloc_p0, sel_p0;

   logic                vld_p1;
   logic [OPCODE_W-1:0] op_p1;
   logic [DATA_W-1:0]   lhs_p1, rhs_p1, imm_p1, pc_p1;
   logic [ROB_W-1:0]    rob_p1;

`ifdef RS_LSB_SNOOP_EN
   assign lsb_sgn = bus.lsb_cdb_sgn;
   assign lsb_rob = bus.lsb_cdb_rob;
   assign lsb_val = bus.lsb_cdb_val;
`else
   assign lsb_sgn = 1'b0;
   assign lsb_rob = '0;
   assign lsb_val = '0;
`endif

   // ALU bus has priority when both buses carry the same tag.
   function automatic snoop_t snoop(input logic [ROB_W-1:0]  tag,
                                    input logic              a_sgn,
                                    input logic [ROB_W-1:0]  a_rob,
                                    input logic [DATA_W-1:0] a_val,
                                    input logic              b_sgn,
                                    input logic [ROB_W-1:0]  b_rob,
                                    input logic [DATA_W-1:0] b_val);
      snoop_t s;
      s.hit = (a_sgn && a_rob == tag) || (b_sgn && b_rob == tag);
      s.val = (a_sgn && a_rob == tag) ? a_val : b_val;
      return s;
   endfunction

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         sj[i]     = snoop(qj_q[i], bus.cdb_sgn, bus.cdb_rob, bus.cdb_val, lsb_sgn, lsb_rob, lsb_val);
         sk[i]     = snoop(qk_q[i], bus.cdb_sgn, bus.cdb_rob, bus.cdb_val, lsb_sgn, lsb_rob, lsb_val);
         wake_j[i] = busy[i] && !rj[i] && sj[i].hit;
         wake_k[i] = busy[i] && !rk[i] && sk[i].hit;
      end
      in_j = snoop(bus.issue_qj, bus.cdb_sgn, bus.cdb_rob, bus.cdb_val, lsb_sgn, lsb_rob, lsb_val);
      in_k = snoop(bus.issue_qk, bus.cdb_sgn, bus.cdb_rob, bus.cdb_val, lsb_sgn, lsb_rob, lsb_val);
   end

   assign ready_req = busy & rj & rk;

   alu_rs_select #(.N(RS_SIZE)) u_free_sel (
      .req (~busy),
      .idx (free_idx),
      .any (free_any)
   );

   alu_rs_select #(.N(RS_SIZE)) u_ready_sel (
      .req (ready_req),
      .idx (sel_idx),
      .any (sel_any)
   );

   // Stage p0: decisions made on pre-edge state; a slot freed now is not reused until next cycle.
   assign bus.rs_full = &busy;
   assign run_p0      = rdy && !flush;
   assign alloc_p0    = run_p0 && bus.issue_sgn && free_any;
   assign sel_p0      = run_p0 && sel_any;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy   <= '0;
         rj     <= '0;
         rk     <= '0;
         vld_p1 <= 1'b0;
      end else if (!rdy) begin
         vld_p1 <= 1'b0;
      end else if (flush) begin
         busy   <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= sel_p0;
         for (int i = 0; i < RS_SIZE; i++) begin
            if (wake_j[i]) rj[i] <= 1'b1;
            if (wake_k[i]) rk[i] <= 1'b1;
         end
         if (sel_p0) busy[sel_idx] <= 1'b0;
         if (alloc_p0) begin
            busy[free_idx] <= 1'b1;
            rj[free_idx]   <= bus.issue_qj_rdy || in_j.hit;
            rk[free_idx]   <= bus.issue_qk_rdy || in_k.hit;
         end
      end
   end

   // Entry payload carries no reset; busy/rj/rk decide whether it means anything.
   always_ff @(posedge clk) begin
      if (run_p0) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (wake_j[i]) vj_q[i] <= sj[i].val;
            if (wake_k[i]) vk_q[i] <= sk[i].val;
         end
         if (alloc_p0) begin
            op_q[free_idx]  <= bus.issue_opcode;
            vj_q[free_idx]  <= bus.issue_qj_rdy ? bus.issue_vj : in_j.val;
            vk_q[free_idx]  <= bus.issue_qk_rdy ? bus.issue_vk : in_k.val;
            qj_q[free_idx]  <= bus.issue_qj;
            qk_q[free_idx]  <= bus.issue_qk;
            imm_q[free_idx] <= bus.issue_imm;
            pc_q[free_idx]  <= bus.issue_pc;
            rob_q[free_idx] <= bus.issue_rob;
         end
      end
   end

   // Stage p1: registered ALU operands, held while nothing issues.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_p1  <= '0;
         lhs_p1 <= '0;
         rhs_p1 <= '0;
         imm_p1 <= '0;
         pc_p1  <= '0;
         rob_p1 <= '0;
      end else if (sel_p0) begin
         op_p1  <= op_q[sel_idx];
         lhs_p1 <= vj_q[sel_idx];
         rhs_p1 <= vk_q[sel_idx];
         imm_p1 <= imm_q[sel_idx];
         pc_p1  <= pc_q[sel_idx];
         rob_p1 <= rob_q[sel_idx];
      end
   end

   assign bus.RS_sgn    = vld_p1;
   assign bus.RS_opcode = op_p1;
   assign bus.lhs       = lhs_p1;
   assign bus.rhs       = rhs_p1;
   assign bus.imm       = imm_p1;
   assign bus.pc        = pc_p1;
   assign bus.ROB_entry = rob_p1;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs with a cycle-level reference model and per-cycle output compare.
module tb_alu_rs;
   import alu_rs_pkg::*;

   localparam int N = 16;

   logic clk, rst, rdy, flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_rs_if #(.ROB_W(4)) bus ();

   alu_rs #(.RS_SIZE(N), .ROB_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of waiting ops plus the last issued op.
   typedef struct {
      bit          busy;
      bit          rj, rk;
      logic [5:0]  op;
      logic [31:0] vj, vk, imm, pc;
      logic [3:0]  qj, qk, rob;
   } ment_t;

   ment_t       m [N];
   bit          mo_vld;
   logic [5:0]  mo_op;
   logic [31:0] mo_lhs, mo_rhs, mo_imm, mo_pc;
   logic [3:0]  mo_rob;

   function automatic bit m_full();
      bit r = 1'b1;
      for (int i = 0; i < N; i++) r = r & m[i].busy;
      return r;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      mo_vld = 0; mo_op = '0; mo_lhs = '0; mo_rhs = '0; mo_imm = '0; mo_pc = '0; mo_rob = '0;
   endtask

   task automatic m_step();
      int sel = -1;
      int fr  = -1;
      if (flush) begin
         for (int i = 0; i < N; i++) m[i].busy = 1'b0;
         mo_vld = 0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (sel < 0 && m[i].busy && m[i].rj && m[i].rk) sel = i;
         if (fr < 0 && !m[i].busy) fr = i;
      end
      mo_vld = (sel >= 0);
      if (sel >= 0) begin
         mo_op = m[sel].op; mo_lhs = m[sel].vj; mo_rhs = m[sel].vk;
         mo_imm = m[sel].imm; mo_pc = m[sel].pc; mo_rob = m[sel].rob;
         m[sel].busy = 1'b0;
      end
      if (bus.cdb_sgn) begin
         for (int i = 0; i < N; i++) begin
            if (m[i].busy && !m[i].rj && m[i].qj == bus.cdb_rob) begin m[i].vj = bus.cdb_val; m[i].rj = 1; end
            if (m[i].busy && !m[i].rk && m[i].qk == bus.cdb_rob) begin m[i].vk = bus.cdb_val; m[i].rk = 1; end
         end
      end
      if (bus.issue_sgn && fr >= 0) begin
         m[fr].busy = 1; m[fr].op = bus.issue_opcode;
         m[fr].qj = bus.issue_qj; m[fr].qk = bus.issue_qk;
         m[fr].imm = bus.issue_imm; m[fr].pc = bus.issue_pc; m[fr].rob = bus.issue_rob;
         m[fr].rj = bus.issue_qj_rdy || (bus.cdb_sgn && bus.cdb_rob == bus.issue_qj);
         m[fr].rk = bus.issue_qk_rdy || (bus.cdb_sgn && bus.cdb_rob == bus.issue_qk);
         m[fr].vj = bus.issue_qj_rdy ? bus.issue_vj : bus.cdb_val;
         m[fr].vk = bus.issue_qk_rdy ? bus.issue_vk : bus.cdb_val;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) m_clear();
      else if (rdy) m_step();
      else mo_vld = 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp.rs_full",   32'(bus.rs_full),   32'(m_full()));
      chk("cmp.RS_sgn",    32'(bus.RS_sgn),    32'(mo_vld));
      chk("cmp.RS_opcode", 32'(bus.RS_opcode), 32'(mo_op));
      chk("cmp.lhs",       bus.lhs,            mo_lhs);
      chk("cmp.rhs",       bus.rhs,            mo_rhs);
      chk("cmp.imm",       bus.imm,            mo_imm);
      chk("cmp.pc",        bus.pc,             mo_pc);
      chk("cmp.ROB_entry", 32'(bus.ROB_entry), 32'(mo_rob));
      if (rst && rdy && bus.issue_sgn && !flush) chk("issue_while_full", 32'(bus.rs_full), 32'd0);
   end

   task automatic expect_out(input string name, input bit sgn, input logic [5:0] op,
                             input logic [31:0] lhs, input logic [31:0] rhs, input logic [3:0] rob);
      chk({name, ".sgn"}, 32'(bus.RS_sgn),    32'(sgn));
      chk({name, ".op"},  32'(bus.RS_opcode), 32'(op));
      chk({name, ".lhs"}, bus.lhs,            lhs);
      chk({name, ".rhs"}, bus.rhs,            rhs);
      chk({name, ".rob"}, 32'(bus.ROB_entry), 32'(rob));
   endtask

   task automatic dispatch(input logic [5:0] op,
                           input logic [31:0] vj, input logic [3:0] qj, input bit rj,
                           input logic [31:0] vk, input logic [3:0] qk, input bit rk,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
      bus.issue_sgn = 1'b1; bus.issue_opcode = op;
      bus.issue_vj = vj; bus.issue_qj = qj; bus.issue_qj_rdy = rj;
      bus.issue_vk = vk; bus.issue_qk = qk; bus.issue_qk_rdy = rk;
      bus.issue_imm = imm; bus.issue_pc = pc; bus.issue_rob = rob;
   endtask

   task automatic cdb(input logic [3:0] rob, input logic [31:0] val);
      bus.cdb_sgn = 1'b1; bus.cdb_rob = rob; bus.cdb_val = val;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.issue_sgn = 1'b0;
      bus.cdb_sgn   = 1'b0;
      flush         = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      bus.issue_sgn = 0; bus.issue_opcode = '0; bus.issue_vj = '0; bus.issue_vk = '0;
      bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_qj_rdy = 0; bus.issue_qk_rdy = 0;
      bus.issue_imm = '0; bus.issue_pc = '0; bus.issue_rob = '0;
      bus.cdb_sgn = 0; bus.cdb_rob = '0; bus.cdb_val = '0;
`ifdef RS_LSB_SNOOP_EN
      bus.lsb_cdb_sgn = 0; bus.lsb_cdb_rob = '0; bus.lsb_cdb_val = '0;
`endif
      #12;
      expect_out("reset", 0, 6'd0, 0, 0, 0);
      chk("reset.rs_full", 32'(bus.rs_full), 0);
      rst = 1'b1;
      step();

      // Single ready op.
      dispatch(OP_ADDI, 5, 0, 1, 0, 0, 1, 3, 32'h100, 2);
      step(); step();
      expect_out("single", 1, OP_ADDI, 5, 0, 2);
      chk("single.imm", bus.imm, 3);
      step();
      chk("single.pulse", 32'(bus.RS_sgn), 0);

      // Wakeup through the CDB.
      dispatch(OP_ADD, 0, 7, 0, 10, 0, 1, 0, 32'h104, 4);
      step(); step();
      chk("wake.wait", 32'(bus.RS_sgn), 0);
      cdb(7, 32);
      step();
      chk("wake.same_cycle", 32'(bus.RS_sgn), 0);
      step();
      expect_out("wake", 1, OP_ADD, 32, 10, 4);

      // Same-cycle CDB bypass on dispatch.
      dispatch(OP_SUB, 20, 0, 1, 0, 3, 0, 0, 32'h108, 5);
      cdb(3, 9);
      step(); step();
      expect_out("bypass", 1, OP_SUB, 20, 9, 5);

      // Fill all entries waiting on tag 1, then drain in index order.
      for (int i = 0; i < N; i++) begin
         dispatch(OP_ADD, 0, 1, 0, 32'(3 * i), 0, 1, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
         step();
      end
      chk("full.rs_full", 32'(bus.rs_full), 1);
      cdb(1, 100);
      step();
      chk("full.woken_wait", 32'(bus.RS_sgn), 0);
      for (int i = 0; i < N; i++) begin
         step();
         expect_out("order", 1, OP_ADD, 100, 32'(3 * i), 4'(i));
         if (i == 0) chk("order.rs_full_drop", 32'(bus.rs_full), 0);
      end
      step();
      chk("order.drained", 32'(bus.RS_sgn), 0);

      // Flush with a simultaneous dispatch.
      for (int i = 0; i < 4; i++) begin
         dispatch(OP_ADD, 0, 9, 0, 1, 0, 1, 0, 0, 4'(8 + i));
         step();
      end
      flush = 1'b1;
      dispatch(OP_ADDI, 77, 0, 1, 0, 0, 1, 0, 0, 12);
      step();
      chk("flush.rs_full", 32'(bus.rs_full), 0);
      chk("flush.sgn", 32'(bus.RS_sgn), 0);
      cdb(9, 55);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush.quiet", 32'(bus.RS_sgn), 0);
      end

      // rdy low freezes everything, including CDB capture.
      dispatch(OP_ADD, 0, 5, 0, 1, 0, 1, 0, 0, 7);
      step();
      dispatch(OP_ADDI, 42, 0, 1, 0, 0, 1, 0, 0, 6);
      step();
      rdy = 1'b0;
      cdb(5, 99);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("rdy_hold", 0, OP_ADD, 100, 45, 15);
      end
      rdy = 1'b1;
      step();
      expect_out("rdy_resume", 1, OP_ADDI, 42, 0, 6);
      step();
      chk("rdy_missed_cdb", 32'(bus.RS_sgn), 0);

      // Asynchronous reset in mid-cycle.
      #2 rst = 1'b0;
      #1;
      expect_out("async_rst", 0, 6'd0, 0, 0, 0);
      chk("async_rst.rs_full", 32'(bus.rs_full), 0);
      #2 rst = 1'b1;
      step();
      cdb(5, 99);
      step(); step();
      chk("async_rst.cleared", 32'(bus.RS_sgn), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU in the Tomasulo out-of-order core.
- Accepts decoded ALU/branch/jump ops from dispatch and holds them until both source operands are ready.
- Snoops the CDB to wake up waiting operands.
- Issues at most one ready op per cycle to the combinational ALU through registered outputs; the ALU puts the result onto the CDB in that same cycle.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- ROB_W, 4, ROB tag width; matches the `ROBENTRY` width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state freezes.
- flush  in  1  mispredict clear from ROB.
- issue_sgn  in  1  dispatch valid.
- issue_opcode  in  6  internal opcode (shared defines).
- issue_vj / issue_vk  in  32  operand values.
- issue_qj / issue_qk  in  ROB_W  producer tags.
- issue_qj_rdy / issue_qk_rdy  in  1  1 = value field is valid.
- issue_imm / issue_pc  in  32  immediate, instruction PC.
- issue_rob  in  ROB_W  destination ROB entry.
- rs_full  out  1  no free entry.
- cdb_sgn  in  1  ALU CDB valid.
- cdb_rob  in  ROB_W  ALU CDB tag.
- cdb_val  in  32  ALU CDB result.
- lsb_cdb_sgn / lsb_cdb_rob / lsb_cdb_val  in  1/ROB_W/32  LSB CDB; present only with RS_LSB_SNOOP_EN.
- RS_sgn  out  1  ALU op valid.
- RS_opcode  out  6  to ALU.
- lhs / rhs / imm / pc  out  32 each  to ALU.
- ROB_entry  out  ROB_W  to ALU.

Behaviour:
- Reset (rst=0, async): all busy bits cleared; RS_sgn=0; RS_opcode/lhs/rhs/imm/pc/ROB_entry=0; rs_full=0.
- Entry fields: busy, opcode, vj, vk, qj, qk, rj, rk, imm, pc, rob.
- rs_full: combinational; equals AND of all busy bits.
- Allocation: on issue_sgn && rdy && !flush, write to the lowest-index free entry.
  - If issue_sgn arrives while rs_full=1, it is ignored; the bench flags this as an error.
- Issue-cycle bypass: if an incoming qX is not ready and matches a valid CDB tag in the same cycle, store the CDB value and set rX=1.
- Wakeup: each cycle, every busy entry with rX=0 and qX==cdb_rob while cdb_sgn=1 captures cdb_val and sets rX=1. Both operands may wake in the same cycle.
- Select: lowest-index entry with busy && rj && rk, evaluated on the pre-edge state.
  - An entry allocated or woken this cycle is selectable next cycle at the earliest.
- Output latency: on the edge after selection, RS_sgn=1 and the fields are driven from the entry (lhs=vj, rhs=vk); the entry's busy bit clears on that same edge.
  - If nothing is selected, RS_sgn=0. RS_sgn is a one-cycle pulse per op.
- Simultaneous events: freeing one entry and allocating another in the same cycle is allowed.
  - The freed slot is not visible to allocation until the next cycle; rs_full uses the pre-edge busy bits.
- flush=1 (with rdy=1): all busy bits cleared; RS_sgn=0 next cycle; flush dominates issue and wakeup.
- rdy=0: no allocation, wakeup, select, or free; RS_sgn forced 0 and the other outputs held.
  - CDB traffic during rdy=0 is not captured; the upstream is frozen too.
- Tag comparison: exact ROB_W-bit equality. No ordering between tags is implied.

Optional Feature:
- Macro: RS_LSB_SNOOP_EN.
- Defined: lsb_cdb_* ports exist; wakeup and issue bypass also match the LSB bus.
  - If both buses match the same operand, the ALU CDB wins. The two tags are distinct by construction.
- Undefined: ports absent; only the ALU CDB is snooped. Load results must then reach the RS through re-dispatch.

Decomposition:
- Shared defines file holds:
  - opcode constants (ADD..JALR).
  - `ROBENTRY`.
  - `RS_SIZE` default.
  - an entry-index width macro.
- Sub-module rs_select: combinational priority encoder over RS_SIZE bits.
  - Produces free_idx/free_any from ~busy.
  - Produces rdy_idx/rdy_any from busy&rj&rk.
  - Instantiated twice.

Test Plan:
- Single ready op: issue ADDI vj=5, imm=3, rj=rk=1, rob=2 -> next cycle RS_sgn=1, RS_opcode=ADDI, lhs=5, ROB_entry=2; following cycle RS_sgn=0.
- Wakeup: issue ADD with qj=7, rj=0 and vk=10 ready; two cycles later drive CDB rob=7, val=32 -> RS_sgn=1 one cycle later with lhs=32, rhs=10.
- Same-cycle bypass: issue SUB with qk=3 not ready while CDB rob=3, val=9 -> captured; RS_sgn=1 next cycle with rhs=9.
- Full/order: issue 16 ops, each waiting on tag 1 -> rs_full=1; broadcast tag 1 -> entries issue one per cycle in index order 0..15; rs_full drops after the first free.
- Flush: 4 busy entries, assert flush together with issue_sgn -> rs_full=0, no RS_sgn afterwards, the new op is not stored.
- Async reset/rdy: hold rdy=0 with a ready entry -> RS_sgn stays 0, entry kept; drop rst mid-cycle -> outputs 0 immediately.
